preg_free_list: RTL and testbench

PREG_FREE_LIST -- requirements
Module: preg_free_list

---
 rtl/qu_common.sv | 12 +
 rtl/alloc_prefix_count.sv | 29 ++
 rtl/preg_free_list.sv | 131 +++++++++++++
 tb/tb_preg_free_list.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// Shared physical-register-file constants for the rename/map stage.
//   PHY_RF_DEPTH      : number of physical registers (power of two)
//   PHY_RF_ADDR_WIDTH : bits needed to index a physical register
//   preg_idx_t        : physical register index type
package qu_common;

   localparam int unsigned PHY_RF_DEPTH      = 128;
   localparam int unsigned PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH);

   typedef logic [PHY_RF_ADDR_WIDTH-1:0] preg_idx_t;

endpackage : qu_common

// File: rtl/alloc_prefix_count.sv
// Slot-offset logic for the free-list allocator. Slots are packed in index
// order, so each requesting slot reads the FIFO at head plus the number of
// requesting slots below it.
// Ports:
//   req_i    : per-slot allocation request
//   offset_o : per-slot count of requesting slots with a lower index
//   total_o  : popcount of req_i
module alloc_prefix_count #(
   parameter int unsigned ALLOC_PORTS = 3,
   parameter int unsigned CNT_W       = $clog2(ALLOC_PORTS + 1)
) (
   input  logic [ALLOC_PORTS-1:0]            req_i,
   output logic [ALLOC_PORTS-1:0][CNT_W-1:0] offset_o,
   output logic [CNT_W-1:0]                  total_o
);

   logic [CNT_W-1:0] run;

   always_comb begin
      run      = '0;
      offset_o = '0;
      for (int unsigned k = 0; k < ALLOC_PORTS; k++) begin
         offset_o[k] = run;
         run         = run + CNT_W'(req_i[k]);
      end
      total_o = run;
   end

endmodule : alloc_prefix_count

// File: rtl/preg_free_list.sv
// Physical register free list: a circular flop-array FIFO of free physical
// register indices. Register 0 is never held. Up to ALLOC_PORTS registers
// are granted per cycle (all-or-nothing) and one is returned per cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   flush        : synchronous return to the reset contents (rel_err kept)
//   alloc_req    : per-slot allocation request (0 = rd, 1 = rs1, 2 = rs2)
//   alloc_grant  : every requested slot is served this cycle
//   alloc_preg   : per-slot granted index, 0 when not granted
//   rel_valid    : one register is returned this cycle
//   rel_preg     : index being returned
//   num_free     : registered count of free entries
//   stall        : fewer than ALLOC_PORTS entries free
//   rel_err      : sticky, a release was rejected
module preg_free_list #(
   parameter int unsigned PHY_RF_DEPTH = qu_common::PHY_RF_DEPTH,
   parameter int unsigned ALLOC_PORTS  = 3
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            flush,
   input  logic [ALLOC_PORTS-1:0]                          alloc_req,
   output logic                                            alloc_grant,
   output logic [ALLOC_PORTS-1:0][$clog2(PHY_RF_DEPTH)-1:0] alloc_preg,
   input  logic                                            rel_valid,
   input  logic [$clog2(PHY_RF_DEPTH)-1:0]                 rel_preg,
   output logic [$clog2(PHY_RF_DEPTH):0]                   num_free,
   output logic                                            stall,
   output logic                                            rel_err
);

   localparam int unsigned AW    = $clog2(PHY_RF_DEPTH);
   localparam int unsigned CNT_W = $clog2(ALLOC_PORTS + 1);
   localparam logic [AW:0] MAX_FREE = (AW+1)'(PHY_RF_DEPTH - 1);

   logic [AW-1:0] fifo_q [PHY_RF_DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          rel_err_q, rel_err_d;

   logic [ALLOC_PORTS-1:0][CNT_W-1:0] slot_off;
   logic [CNT_W-1:0]                  req_cnt;
   logic [AW:0]                       req_cnt_w;
   logic [ALLOC_PORTS-1:0][AW-1:0]    rd_idx;
   logic                              grant;
   logic                              rel_ok;
   logic                              rel_accept;

   alloc_prefix_count #(
      .ALLOC_PORTS(ALLOC_PORTS),
      .CNT_W      (CNT_W)
   ) u_prefix (
      .req_i   (alloc_req),
      .offset_o(slot_off),
      .total_o (req_cnt)
   );

   assign req_cnt_w = (AW+1)'(req_cnt);

   // rst gates the grant so nothing is handed out while reset is held.
   assign grant = (req_cnt_w != '0) && (req_cnt_w <= count_q) && !flush && !rst;

   // Acceptance is judged on the pre-grant count, so a full list rejects
   // even if this cycle's grant would have made room.
   assign rel_ok     = (rel_preg != '0) && (count_q != MAX_FREE);
   assign rel_accept = rel_valid && !flush && rel_ok;

   // Reads come only from registered FIFO contents; a same-cycle release
   // lands at tail and is not seen until the next cycle.
   always_comb begin
      alloc_preg = '0;
      rd_idx     = '0;
      for (int unsigned k = 0; k < ALLOC_PORTS; k++) begin
         rd_idx[k] = head_q + AW'(slot_off[k]);
         if (grant && alloc_req[k]) begin
            alloc_preg[k] = fifo_q[rd_idx[k]];
         end
      end
   end

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      rel_err_d = rel_err_q;
      if (grant) begin
         head_d = head_q + AW'(req_cnt);
      end
      if (rel_accept) begin
         tail_d = tail_q + AW'(1);
      end
      count_d = count_q - (grant ? req_cnt_w : '0) + (rel_accept ? (AW+1)'(1) : '0);
      if (rel_valid && !flush && !rel_ok) begin
         rel_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < PHY_RF_DEPTH; i++) begin
            fifo_q[i] <= (i < PHY_RF_DEPTH - 1) ? AW'(i + 1) : '0;
         end
         head_q    <= '0;
         tail_q    <= AW'(PHY_RF_DEPTH - 1);
         count_q   <= MAX_FREE;
         rel_err_q <= 1'b0;
      end else if (flush) begin
         for (int unsigned i = 0; i < PHY_RF_DEPTH; i++) begin
            fifo_q[i] <= (i < PHY_RF_DEPTH - 1) ? AW'(i + 1) : '0;
         end
         head_q  <= '0;
         tail_q  <= AW'(PHY_RF_DEPTH - 1);
         count_q <= MAX_FREE;
      end else begin
         if (rel_accept) begin
            fifo_q[tail_q] <= rel_preg;
         end
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         rel_err_q <= rel_err_d;
      end
   end

   assign alloc_grant = grant;
   assign num_free    = count_q;
   assign stall       = count_q < (AW+1)'(ALLOC_PORTS);
   assign rel_err     = rel_err_q;

endmodule : preg_free_list

// File: tb/tb_preg_free_list.sv
module tb_preg_free_list;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [2:0]      alloc_req;
   logic            alloc_grant;
   logic [2:0][6:0] alloc_preg;
   logic            rel_valid;
   logic [6:0]      rel_preg;
   logic [7:0]      num_free;
   logic            stall;
   logic            rel_err;

   int checks   = 0;
   int failures = 0;

   // Reference model: ordered list of free registers plus allocated set.
   int m_free[$];
   int m_inuse[$];
   bit m_err;

   logic            obs_grant;
   logic [2:0][6:0] obs_preg;
   logic [7:0]      obs_nf;
   logic            obs_stall;
   logic            obs_err;

   preg_free_list #(
      .PHY_RF_DEPTH(128),
      .ALLOC_PORTS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .alloc_req  (alloc_req),
      .alloc_grant(alloc_grant),
      .alloc_preg (alloc_preg),
      .rel_valid  (rel_valid),
      .rel_preg   (rel_preg),
      .num_free   (num_free),
      .stall      (stall),
      .rel_err    (rel_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset(input bit clear_err);
      m_free.delete();
      for (int i = 1; i < 128; i++) m_free.push_back(i);
      m_inuse.delete();
      if (clear_err) m_err = 1'b0;
   endfunction

   // Drive one cycle, compare every output against the model, advance model.
   task automatic step(input logic [2:0] req, input logic rv, input logic [6:0] rp, input logic fl);
      int              rc;
      int              n;
      bit              g;
      bit              acc;
      logic [2:0][6:0] ep;
      int              got[$];
      @(negedge clk);
      alloc_req = req;
      rel_valid = rv;
      rel_preg  = rp;
      flush     = fl;
      #1;
      rc = $countones(req);
      g  = (rc != 0) && (rc <= m_free.size()) && !fl;
      ep = '0;
      n  = 0;
      for (int k = 0; k < 3; k++) begin
         if (req[k]) begin
            if (g) ep[k] = 7'(m_free[n]);
            n++;
         end
      end
      obs_grant = alloc_grant;
      obs_preg  = alloc_preg;
      obs_nf    = num_free;
      obs_stall = stall;
      obs_err   = rel_err;
      chk("grant", 32'(alloc_grant), 32'(g));
      chk("preg", 32'(alloc_preg), 32'(ep));
      chk("num_free", 32'(num_free), 32'(m_free.size()));
      chk("stall", 32'(stall), 32'(m_free.size() < 3));
      chk("rel_err", 32'(rel_err), 32'(m_err));
      acc = rv && !fl && (rp != 0) && (m_free.size() != 127);
      if (fl) begin
         model_reset(1'b0);
      end else begin
         if (g) begin
            for (int i = 0; i < rc; i++) begin
               got.push_back(m_free.pop_front());
            end
            foreach (got[i]) m_inuse.push_back(got[i]);
         end
         if (acc) begin
            m_free.push_back(int'(rp));
            for (int i = 0; i < m_inuse.size(); i++) begin
               if (m_inuse[i] == int'(rp)) begin
                  m_inuse.delete(i);
                  break;
               end
            end
         end else if (rv) begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst       = 1'b1;
      alloc_req = 3'b111;
      rel_valid = 1'b0;
      flush     = 1'b0;
      #2;
      chk("rst_grant", 32'(alloc_grant), 32'd0);
      chk("rst_preg", 32'(alloc_preg), 32'd0);
      chk("rst_num_free", 32'(num_free), 32'd127);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_err", 32'(rel_err), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      alloc_req = '0;
      model_reset(1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      alloc_req = '0;
      rel_valid = 1'b0;
      rel_preg  = '0;
      m_err     = 1'b0;
      model_reset(1'b1);
      repeat (2) @(negedge clk);
      do_reset();

      // Full three-slot allocation from reset.
      step(3'b111, 1'b0, 7'd0, 1'b0);
      chk("lit_grant_111", 32'(obs_grant), 32'd1);
      chk("lit_preg_111", 32'(obs_preg), 32'({7'd3, 7'd2, 7'd1}));
      step(3'b000, 1'b0, 7'd0, 1'b0);
      chk("lit_nf_124", 32'(obs_nf), 32'd124);

      // Sparse request packs slots 0 and 2.
      do_reset();
      step(3'b101, 1'b0, 7'd0, 1'b0);
      chk("lit_preg_101", 32'(obs_preg), 32'({7'd2, 7'd0, 7'd1}));
      step(3'b001, 1'b0, 7'd0, 1'b0);
      chk("lit_head_2", 32'(obs_preg[0]), 32'd3);
      chk("lit_nf_125", 32'(obs_nf), 32'd125);

      // Drain to two free entries, then partial-fit and exact-fit requests.
      do_reset();
      repeat (41) step(3'b111, 1'b0, 7'd0, 1'b0);
      repeat (2) step(3'b001, 1'b0, 7'd0, 1'b0);
      step(3'b111, 1'b0, 7'd0, 1'b0);
      chk("lit_nofit_grant", 32'(obs_grant), 32'd0);
      chk("lit_nofit_stall", 32'(obs_stall), 32'd1);
      chk("lit_nofit_nf", 32'(obs_nf), 32'd2);
      step(3'b011, 1'b0, 7'd0, 1'b0);
      chk("lit_fit_grant", 32'(obs_grant), 32'd1);
      chk("lit_fit_preg", 32'(obs_preg), 32'({7'd0, 7'd127, 7'd126}));
      // Empty list: release does not bypass to a same-cycle request.
      step(3'b001, 1'b1, 7'd9, 1'b0);
      chk("lit_empty_nf", 32'(obs_nf), 32'd0);
      chk("lit_nobypass", 32'(obs_grant), 32'd0);
      step(3'b001, 1'b0, 7'd0, 1'b0);
      chk("lit_rel9_grant", 32'(obs_grant), 32'd1);
      chk("lit_rel9_preg", 32'(obs_preg[0]), 32'd9);

      // Rejected releases set the sticky error; flush keeps it.
      do_reset();
      step(3'b000, 1'b1, 7'd5, 1'b0);
      step(3'b000, 1'b1, 7'd0, 1'b0);
      chk("lit_err_full", 32'(obs_err), 32'd1);
      chk("lit_err_nf", 32'(obs_nf), 32'd127);
      step(3'b000, 1'b0, 7'd0, 1'b1);
      step(3'b000, 1'b0, 7'd0, 1'b0);
      chk("lit_err_flush", 32'(obs_err), 32'd1);

      // Flush beats a same-cycle allocation.
      do_reset();
      repeat (40) step(3'b001, 1'b0, 7'd0, 1'b0);
      step(3'b111, 1'b0, 7'd0, 1'b1);
      chk("lit_flush_grant", 32'(obs_grant), 32'd0);
      chk("lit_flush_nf", 32'(obs_nf), 32'd87);
      step(3'b111, 1'b0, 7'd0, 1'b0);
      chk("lit_post_flush_nf", 32'(obs_nf), 32'd127);
      chk("lit_post_flush_preg", 32'(obs_preg), 32'({7'd3, 7'd2, 7'd1}));

      // Randomised traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [2:0] rq;
         logic       rv;
         logic [6:0] rp;
         logic       fl;
         int         r;
         rq = 3'($urandom_range(0, 7));
         rv = 1'b0;
         rp = '0;
         r  = int'($urandom_range(0, 99));
         if (r < 5) begin
            rv = 1'b1;
            rp = '0;
         end else if (r < 8) begin
            rv = 1'b1;
            rp = 7'($urandom_range(1, 127));
         end else if (r < 60 && m_inuse.size() != 0) begin
            rv = 1'b1;
            rp = 7'(m_inuse[$urandom_range(0, m_inuse.size() - 1)]);
         end
         fl = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            step(rq, rv, rp, fl);
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_preg_free_list
